hazard_ctrl: RTL

//  Hazard detection, forwarding select and stall/flush sequencer for the 5-stage MIPS pipeline.

---
 rtl/hazard_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Hazard detection, EX forwarding select and mult/div stall sequencer for the 5-stage pipeline.
// Define FORWARDING_EN for bypassing with load-use stalls; otherwise every EX/MEM RAW stalls.
module hazard_ctrl #(
   parameter int MC_LATENCY = 4,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       Rs_ID,
   input  logic [4:0]       Rt_ID,
   input  logic             UsesRt_ID,
   input  logic             BranchTaken_ID,
   input  logic [4:0]       Rs_Ex,
   input  logic [4:0]       Rt_Ex,
   input  logic [4:0]       WriteReg_Ex,
   input  logic             RegWrite_Ex,
   input  logic             MemtoReg_Ex,
   input  logic             MCStart_Ex,
   input  logic [4:0]       WriteReg_Mem,
   input  logic             RegWrite_Mem,
   input  logic [4:0]       WriteReg_WB,
   input  logic             RegWrite_WB,
   output logic             Stall_IF,
   output logic             Stall_ID,
   output logic             Stall_Ex,
   output logic             Flush_ID,
   output logic             Flush_Ex,
   output logic [1:0]       ForwardA_Ex,
   output logic [1:0]       ForwardB_Ex,
   output logic [CNT_W-1:0] StallCnt,
   output logic             o_dbg_mcwait
);

   localparam int CW = (MC_LATENCY > 2) ? $clog2(MC_LATENCY - 1) : 1;
   localparam logic [CW-1:0] MC_INIT = CW'(MC_LATENCY - 2);

   typedef enum logic {ST_RUN = 1'b0, ST_MCWAIT = 1'b1} state_t;

   state_t           r_state;
   logic [CW-1:0]    r_wait_cnt;
   logic [CNT_W-1:0] r_stall_cnt;

   logic       w_mcwait;
   logic       w_hazard;
   logic       w_stall;
   logic       w_rs_hit_ex;
   logic       w_rt_hit_ex;
   logic [1:0] w_fwd_a;
   logic [1:0] w_fwd_b;

   assign w_mcwait    = (r_state == ST_MCWAIT);
   assign w_rs_hit_ex = RegWrite_Ex && (WriteReg_Ex != 5'd0) && (WriteReg_Ex == Rs_ID);
   assign w_rt_hit_ex = RegWrite_Ex && (WriteReg_Ex != 5'd0) && UsesRt_ID && (WriteReg_Ex == Rt_ID);

`ifdef FORWARDING_EN
   // Only a load in EX cannot be bypassed in time; everything else forwards.
   assign w_hazard = MemtoReg_Ex && (w_rs_hit_ex || w_rt_hit_ex);

   always_comb begin
      w_fwd_a = 2'b00;
      w_fwd_b = 2'b00;
      if (RegWrite_Mem && (WriteReg_Mem != 5'd0) && (WriteReg_Mem == Rs_Ex))
         w_fwd_a = 2'b10;
      else if (RegWrite_WB && (WriteReg_WB != 5'd0) && (WriteReg_WB == Rs_Ex))
         w_fwd_a = 2'b01;
      if (RegWrite_Mem && (WriteReg_Mem != 5'd0) && (WriteReg_Mem == Rt_Ex))
         w_fwd_b = 2'b10;
      else if (RegWrite_WB && (WriteReg_WB != 5'd0) && (WriteReg_WB == Rt_Ex))
         w_fwd_b = 2'b01;
   end
`else
   logic w_rs_hit_mem;
   logic w_rt_hit_mem;
   logic w_unused_nofwd;

   assign w_rs_hit_mem = RegWrite_Mem && (WriteReg_Mem != 5'd0) && (WriteReg_Mem == Rs_ID);
   assign w_rt_hit_mem = RegWrite_Mem && (WriteReg_Mem != 5'd0) && UsesRt_ID && (WriteReg_Mem == Rt_ID);
   // WB writes the regfile before ID reads it, so only EX and MEM producers stall.
   assign w_hazard = w_rs_hit_ex || w_rt_hit_ex || w_rs_hit_mem || w_rt_hit_mem;
   assign w_fwd_a  = 2'b00;
   assign w_fwd_b  = 2'b00;
   assign w_unused_nofwd = ^{Rs_Ex, Rt_Ex, MemtoReg_Ex, WriteReg_WB, RegWrite_WB};
`endif

   assign w_stall = w_mcwait || w_hazard;

   assign Stall_IF     = rst && w_stall;
   assign Stall_ID     = rst && w_stall;
   assign Stall_Ex     = rst && w_mcwait;
   assign Flush_Ex     = rst && !w_mcwait && w_hazard;
   assign Flush_ID     = rst && !w_mcwait && !w_hazard && BranchTaken_ID;
   assign ForwardA_Ex  = rst ? w_fwd_a : 2'b00;
   assign ForwardB_Ex  = rst ? w_fwd_b : 2'b00;
   assign StallCnt     = r_stall_cnt;
   assign o_dbg_mcwait = w_mcwait;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_RUN;
         r_wait_cnt  <= '0;
         r_stall_cnt <= '0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (MCStart_Ex) begin
                  r_state    <= ST_MCWAIT;
                  r_wait_cnt <= MC_INIT;
               end
            end
            ST_MCWAIT: begin
               if (r_wait_cnt == '0)
                  r_state <= ST_RUN;
               else
                  r_wait_cnt <= r_wait_cnt - 1'b1;
            end
            default: r_state <= ST_RUN;
         endcase
         if (w_stall && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

endmodule
